// File: rtl/usb_txn_scheduler.sv
// Host-side USB transaction scheduler: round-robin endpoint arbitration, then
// token / data / handshake sequencing with per-endpoint data toggles and timeout retry.
module usb_txn_scheduler #(
  parameter int NUM_EP    = 4,
  parameter int RETRY_MAX = 3,
  parameter int TW        = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_EP-1:0] req_i,
  input  logic [NUM_EP-1:0] req_dir_i,
  output logic [NUM_EP-1:0] grant_o,
  output logic              done_o,
  output logic [1:0]        status_o,
  output logic              rx_discard_o,
  output logic              tok_start_o,
  output logic [3:0]        tok_pid_o,
  output logic [2:0]        tok_ep_o,
  input  logic              tok_done_i,
  output logic              dat_start_o,
  output logic [3:0]        dat_pid_o,
  input  logic              dat_done_i,
  input  logic              rx_pid_en_i,
  input  logic [3:0]        rx_pid_i,
  input  logic              rx_eop_en_i,
  output logic              hs_start_o,
  input  logic              hs_done_i,
  input  logic [TW-1:0]     time_threshold_i,
  output logic              d_oe_o,
  output logic              busy_o
);

  localparam int IW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_TOKEN, S_OUT_DATA, S_WAIT_HS,
    S_WAIT_DATA, S_RX_DATA, S_SEND_ACK, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              dir_q, dir_d;
  logic [NUM_EP-1:0] grant_q, grant_d;
  logic [NUM_EP-1:0] toggle_q, toggle_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              match_q, match_d;
  logic [1:0]        status_q, status_d;
  logic              done_q, done_d;
  logic              rx_discard_q, rx_discard_d;
  logic              tok_start_q, tok_start_d;
  logic              dat_start_q, dat_start_d;
  logic              hs_start_q, hs_start_d;
  logic [3:0]        tok_pid_q, tok_pid_d;
  logic [2:0]        tok_ep_q, tok_ep_d;
  logic [3:0]        dat_pid_q, dat_pid_d;
  logic              d_oe_q, d_oe_d;

  logic [IW-1:0]     arb_idx;
  logic              arb_found;
  logic [NUM_EP-1:0] arb_onehot;
  logic              timeout;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_EP) sum = sum - NUM_EP;
    return IW'(sum);
  endfunction

  // Scan from the farthest candidate to the nearest so the nearest set bit after the pointer wins.
  always_comb begin
    arb_idx   = ptr_q;
    arb_found = 1'b0;
    for (int off = NUM_EP; off >= 1; off--) begin
      if (req_i[wrap_add(ptr_q, off)]) begin
        arb_idx   = wrap_add(ptr_q, off);
        arb_found = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_EP; gi++) begin : g_onehot
    assign arb_onehot[gi] = (arb_idx == IW'(gi));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      ptr_q        <= IW'(NUM_EP - 1);
      idx_q        <= '0;
      dir_q        <= 1'b0;
      grant_q      <= '0;
      toggle_q     <= '0;
      retry_q      <= '0;
      timer_q      <= '0;
      match_q      <= 1'b0;
      status_q     <= 2'b00;
      done_q       <= 1'b0;
      rx_discard_q <= 1'b0;
      tok_start_q  <= 1'b0;
      dat_start_q  <= 1'b0;
      hs_start_q   <= 1'b0;
      tok_pid_q    <= 4'b0000;
      tok_ep_q     <= 3'b000;
      dat_pid_q    <= 4'b0000;
      d_oe_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      dir_q        <= dir_d;
      grant_q      <= grant_d;
      toggle_q     <= toggle_d;
      retry_q      <= retry_d;
      timer_q      <= timer_d;
      match_q      <= match_d;
      status_q     <= status_d;
      done_q       <= done_d;
      rx_discard_q <= rx_discard_d;
      tok_start_q  <= tok_start_d;
      dat_start_q  <= dat_start_d;
      hs_start_q   <= hs_start_d;
      tok_pid_q    <= tok_pid_d;
      tok_ep_q     <= tok_ep_d;
      dat_pid_q    <= dat_pid_d;
      d_oe_q       <= d_oe_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    dir_d        = dir_q;
    grant_d      = grant_q;
    toggle_d     = toggle_q;
    retry_d      = retry_q;
    match_d      = match_q;
    status_d     = status_q;
    rx_discard_d = 1'b0;
    tok_start_d  = 1'b0;
    dat_start_d  = 1'b0;
    hs_start_d   = 1'b0;
    tok_pid_d    = tok_pid_q;
    tok_ep_d     = tok_ep_q;
    dat_pid_d    = dat_pid_q;
    timeout      = 1'b0;
    timer_d      = (timer_q == '1) ? timer_q : timer_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (|req_i) state_d = S_ARB;
      end
      S_ARB: begin
        // A request withdrawn before arbitration simply returns to idle.
        if (arb_found) begin
          ptr_d       = arb_idx;
          idx_d       = arb_idx;
          dir_d       = req_dir_i[arb_idx];
          grant_d     = arb_onehot;
          retry_d     = '0;
          tok_pid_d   = req_dir_i[arb_idx] ? PID_IN : PID_OUT;
          tok_ep_d    = 3'(arb_idx);
          tok_start_d = 1'b1;
          state_d     = S_TOKEN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TOKEN: begin
        if (tok_done_i) begin
          timer_d = '0;
          if (dir_q) begin
            state_d = S_WAIT_DATA;
          end else begin
            dat_pid_d   = toggle_q[idx_q] ? PID_DATA1 : PID_DATA0;
            dat_start_d = 1'b1;
            state_d     = S_OUT_DATA;
          end
        end
      end
      S_OUT_DATA: begin
        if (dat_done_i) begin
          timer_d = '0;
          state_d = S_WAIT_HS;
        end
      end
      S_WAIT_HS: begin
        if (rx_pid_en_i) begin
          case (rx_pid_i)
            PID_ACK: begin
              toggle_d[idx_q] = ~toggle_q[idx_q];
              status_d        = 2'b00;
              state_d         = S_DONE;
            end
            PID_NAK: begin
              status_d = 2'b01;
              state_d  = S_DONE;
            end
            PID_STALL: begin
              status_d = 2'b10;
              state_d  = S_DONE;
            end
            default: timeout = 1'b1;
          endcase
        end else if (timer_q == time_threshold_i) begin
          timeout = 1'b1;
        end
      end
      S_WAIT_DATA: begin
        if (rx_pid_en_i) begin
          case (rx_pid_i)
            PID_DATA0, PID_DATA1: begin
              match_d = (rx_pid_i[3] == toggle_q[idx_q]);
              state_d = S_RX_DATA;
            end
            PID_NAK: begin
              status_d = 2'b01;
              state_d  = S_DONE;
            end
            PID_STALL: begin
              status_d = 2'b10;
              state_d  = S_DONE;
            end
            default: timeout = 1'b1;
          endcase
        end else if (timer_q == time_threshold_i) begin
          timeout = 1'b1;
        end
      end
      S_RX_DATA: begin
        if (rx_eop_en_i) begin
          hs_start_d = 1'b1;
          state_d    = S_SEND_ACK;
        end
      end
      S_SEND_ACK: begin
        // Duplicate data is still acknowledged so the device advances, but is flagged for discard.
        if (hs_done_i) begin
          if (match_q) toggle_d[idx_q] = ~toggle_q[idx_q];
          rx_discard_d = ~match_q;
          status_d     = 2'b00;
          state_d      = S_DONE;
        end
      end
      S_DONE: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      if (retry_q < RETRY_LIM) begin
        retry_d     = retry_q + 1'b1;
        tok_start_d = 1'b1;
        state_d     = S_TOKEN;
      end else begin
        status_d = 2'b11;
        state_d  = S_DONE;
      end
    end

    done_d = (state_d == S_DONE);
    d_oe_d = (state_d == S_TOKEN) || (state_d == S_OUT_DATA) || (state_d == S_SEND_ACK);
  end

  assign grant_o      = grant_q;
  assign done_o       = done_q;
  assign status_o     = status_q;
  assign rx_discard_o = rx_discard_q;
  assign tok_start_o  = tok_start_q;
  assign tok_pid_o    = tok_pid_q;
  assign tok_ep_o     = tok_ep_q;
  assign dat_start_o  = dat_start_q;
  assign dat_pid_o    = dat_pid_q;
  assign hs_start_o   = hs_start_q;
  assign d_oe_o       = d_oe_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_usb_txn_scheduler.sv
// Directed bench for usb_txn_scheduler: a transaction-level model predicts grant,
// PIDs, status, discard and token counts; outputs are compared every cycle.
module tb_usb_txn_scheduler;
  localparam int NUM_EP    = 4;
  localparam int RETRY_MAX = 3;
  localparam int TW        = 16;

  localparam logic [3:0] P_ACK   = 4'b0010;
  localparam logic [3:0] P_NAK   = 4'b1010;
  localparam logic [3:0] P_STALL = 4'b1110;
  localparam logic [3:0] P_DATA0 = 4'b0011;
  localparam logic [3:0] P_DATA1 = 4'b1011;

  localparam int K_REPLY  = 0;
  localparam int K_SILENT = 1;
  localparam int K_RESET  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_EP-1:0] req_i, req_dir_i, grant_o;
  logic              done_o, rx_discard_o, tok_start_o, dat_start_o, hs_start_o;
  logic [1:0]        status_o;
  logic [3:0]        tok_pid_o, dat_pid_o, rx_pid_i;
  logic [2:0]        tok_ep_o;
  logic              tok_done_i, dat_done_i, rx_pid_en_i, rx_eop_en_i, hs_done_i;
  logic [TW-1:0]     thr;
  logic              d_oe_o, busy_o;

  always #5 clk = ~clk;

  usb_txn_scheduler #(.NUM_EP(NUM_EP), .RETRY_MAX(RETRY_MAX), .TW(TW)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req_i), .req_dir_i(req_dir_i), .grant_o(grant_o),
    .done_o(done_o), .status_o(status_o), .rx_discard_o(rx_discard_o),
    .tok_start_o(tok_start_o), .tok_pid_o(tok_pid_o), .tok_ep_o(tok_ep_o), .tok_done_i(tok_done_i),
    .dat_start_o(dat_start_o), .dat_pid_o(dat_pid_o), .dat_done_i(dat_done_i),
    .rx_pid_en_i(rx_pid_en_i), .rx_pid_i(rx_pid_i), .rx_eop_en_i(rx_eop_en_i),
    .hs_start_o(hs_start_o), .hs_done_i(hs_done_i), .time_threshold_i(thr),
    .d_oe_o(d_oe_o), .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;
  int txn_no = 0;

  // Model state: round-robin pointer and per-endpoint data toggles.
  int         m_ptr;
  logic [3:0] m_tog;

  int         exp_ep, exp_tokens, exp_hs;
  logic [3:0] exp_tok_pid, exp_dat_pid;
  logic [1:0] exp_status;
  logic       exp_discard;
  int         tok_cnt, hs_cnt;
  int         obs_tok_ep, obs_dat_pid, obs_status, obs_discard, obs_tokens;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r);
    for (int k = 1; k <= NUM_EP; k++) begin
      if (r[(m_ptr + k) % NUM_EP]) return (m_ptr + k) % NUM_EP;
    end
    return -1;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_grant"}, int'(grant_o), 0);
    check({tag, "_done"}, int'(done_o), 0);
    check({tag, "_status"}, int'(status_o), 0);
    check({tag, "_discard"}, int'(rx_discard_o), 0);
    check({tag, "_strobes"}, int'({tok_start_o, dat_start_o, hs_start_o}), 0);
    check({tag, "_d_oe"}, int'(d_oe_o), 0);
    check({tag, "_busy"}, int'(busy_o), 0);
    check({tag, "_tok_pid"}, int'(tok_pid_o), 0);
    check({tag, "_tok_ep"}, int'(tok_ep_o), 0);
    check({tag, "_dat_pid"}, int'(dat_pid_o), 0);
  endtask

  // Per-cycle comparison of DUT outputs against the model's expectations.
  task automatic compare_cycle();
    if (tok_start_o) begin
      tok_cnt++;
      obs_tok_ep = int'(tok_ep_o);
      check("tok_pid", int'(tok_pid_o), int'(exp_tok_pid));
      check("tok_ep", int'(tok_ep_o), exp_ep);
      check("grant_at_token", int'(grant_o), 1 << exp_ep);
      check("d_oe_token", int'(d_oe_o), 1);
    end
    if (dat_start_o) begin
      obs_dat_pid = int'(dat_pid_o);
      check("dat_pid", int'(dat_pid_o), int'(exp_dat_pid));
      check("d_oe_data", int'(d_oe_o), 1);
    end
    if (hs_start_o) begin
      hs_cnt++;
      check("d_oe_hs", int'(d_oe_o), 1);
    end
    if (done_o) begin
      obs_status  = int'(status_o);
      obs_discard = int'(rx_discard_o);
      obs_tokens  = tok_cnt;
      check("status", int'(status_o), int'(exp_status));
      check("rx_discard", int'(rx_discard_o), int'(exp_discard));
      check("grant_at_done", int'(grant_o), 1 << exp_ep);
      check("d_oe_done", int'(d_oe_o), 0);
      check("token_count", tok_cnt, exp_tokens);
      check("hs_count", hs_cnt, exp_hs);
    end
    if (!busy_o) check("idle_quiet", int'({grant_o, d_oe_o, done_o, tok_start_o}), 0);
  endtask

  task automatic run_txn(input logic [3:0] reqm, input logic [3:0] dirm, input int kind,
                         input int dly, input logic [3:0] rpid);
    bit fin, armed, eop_pend, is_in, is_data, match;
    int wcnt;
    exp_ep      = pick(reqm);
    is_in       = dirm[exp_ep];
    exp_tok_pid = is_in ? 4'b1001 : 4'b0001;
    exp_dat_pid = {m_tog[exp_ep], 3'b011};
    exp_tokens  = (kind == K_SILENT) ? RETRY_MAX + 1 : 1;
    if (kind == K_SILENT)    exp_status = 2'b11;
    else if (rpid == P_NAK)   exp_status = 2'b01;
    else if (rpid == P_STALL) exp_status = 2'b10;
    else                      exp_status = 2'b00;
    is_data     = (kind == K_REPLY) && is_in && (rpid == P_DATA0 || rpid == P_DATA1);
    match       = (rpid[3] == m_tog[exp_ep]);
    exp_discard = is_data && !match;
    exp_hs      = is_data ? 1 : 0;
    tok_cnt = 0; hs_cnt = 0;
    fin = 0; armed = 0; eop_pend = 0; wcnt = 0;
    req_i = reqm; req_dir_i = dirm;
    for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
      @(negedge clk);
      {tok_done_i, dat_done_i, rx_pid_en_i, rx_eop_en_i, hs_done_i} = '0;
      compare_cycle();
      if (done_o) begin
        fin = 1;
        if (kind == K_SILENT) check("wait_len_last", wcnt, int'(thr) + 1);
      end else if (tok_start_o) begin
        if (armed) check("wait_len", wcnt, int'(thr) + 1);
        tok_done_i = 1; armed = is_in; wcnt = 0;
      end else if (dat_start_o) begin
        dat_done_i = 1; armed = 1; wcnt = 0;
      end else if (hs_start_o) begin
        hs_done_i = 1;
      end else if (eop_pend) begin
        rx_eop_en_i = 1; eop_pend = 0;
      end else if (armed) begin
        wcnt++;
        if (wcnt == 1) check("d_oe_wait", int'(d_oe_o), 0);
        if (kind == K_REPLY && wcnt == dly) begin
          rx_pid_en_i = 1; rx_pid_i = rpid; armed = 0; eop_pend = is_data;
        end else if (kind == K_RESET && wcnt == dly) begin
          rst = 1;
          #1;
          check_reset_values("rst_mid");
          fin = 1;
        end
      end
    end
    if (!fin) check("txn_complete", 0, 1);
    req_i = '0; req_dir_i = '0;
    if (kind == K_RESET) begin
      @(negedge clk);
      check_reset_values("rst_held");
      rst = 0;
      m_ptr = NUM_EP - 1;
      m_tog = '0;
    end else begin
      m_ptr = exp_ep;
      if (kind == K_REPLY && ((!is_in && rpid == P_ACK) || (is_data && match)))
        m_tog[exp_ep] = ~m_tog[exp_ep];
    end
    txn_no++;
    $display("txn %0d: ep%0d %s kind=%0d tokens=%0d status=%0d discard=%0d", txn_no, exp_ep,
             is_in ? "IN " : "OUT", kind, tok_cnt, obs_status, obs_discard);
    repeat (3) begin
      @(negedge clk);
      compare_cycle();
    end
  endtask

  initial begin
    int order [5];
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    rst = 1; req_i = '0; req_dir_i = '0; rx_pid_i = '0; thr = 16'd20;
    {tok_done_i, dat_done_i, rx_pid_en_i, rx_eop_en_i, hs_done_i} = '0;
    m_ptr = NUM_EP - 1; m_tog = '0;
    obs_tok_ep = -1; obs_dat_pid = -1; obs_status = -1; obs_discard = -1; obs_tokens = -1;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 0;
    @(negedge clk);

    // IN on ep1: fresh DATA0, then a repeated DATA0
    run_txn(4'b0010, 4'b0010, K_REPLY, 3, P_DATA0);
    check("lit_in1_ep", obs_tok_ep, 1);
    check("lit_in1_status", obs_status, 0);
    check("lit_in1_discard", obs_discard, 0);
    run_txn(4'b0010, 4'b0010, K_REPLY, 2, P_DATA0);
    check("lit_in2_discard", obs_discard, 1);
    run_txn(4'b0010, 4'b0010, K_REPLY, 2, P_DATA1);
    check("lit_in3_discard", obs_discard, 0);

    // OUT toggling on ep2
    run_txn(4'b0100, 4'b0000, K_REPLY, 2, P_ACK);
    check("lit_out1_pid", obs_dat_pid, 4'b0011);
    run_txn(4'b0100, 4'b0000, K_REPLY, 2, P_ACK);
    check("lit_out2_pid", obs_dat_pid, 4'b1011);
    run_txn(4'b0100, 4'b0000, K_REPLY, 2, P_NAK);
    check("lit_nak_pid", obs_dat_pid, 4'b0011);
    check("lit_nak_status", obs_status, 1);
    run_txn(4'b0100, 4'b0000, K_REPLY, 2, P_ACK);
    check("lit_after_nak_pid", obs_dat_pid, 4'b0011);

    // Reset while waiting for the handshake; ep2 toggle was 1
    run_txn(4'b0100, 4'b0000, K_RESET, 3, 4'b0000);

    // Fair arbitration, all OUT, all ACK
    for (int i = 0; i < 5; i++) begin
      run_txn(4'b1111, 4'b0000, K_REPLY, 2, P_ACK);
      check("lit_fair_ep", obs_tok_ep, order[i]);
      check("lit_fair_status", obs_status, 0);
      if (i == 2) check("lit_fair_ep2_pid_cleared", obs_dat_pid, 4'b0011);
    end

    // No response: four tokens, 11-cycle waits, then error status
    thr = 16'd10;
    run_txn(4'b1000, 4'b0000, K_SILENT, 0, 4'b0000);
    check("lit_to_status", obs_status, 3);
    check("lit_to_tokens", obs_tokens, 4);

    // ACK exactly in the threshold cycle
    thr = 16'd5;
    run_txn(4'b1000, 4'b0000, K_REPLY, 6, P_ACK);
    check("lit_thr_status", obs_status, 0);
    check("lit_thr_tokens", obs_tokens, 1);

    // Threshold zero with ACK in the first wait cycle
    thr = 16'd0;
    run_txn(4'b0001, 4'b0000, K_REPLY, 1, P_ACK);
    check("lit_thr0_tokens", obs_tokens, 1);

    // STALL on IN
    thr = 16'd20;
    run_txn(4'b0001, 4'b0001, K_REPLY, 2, P_STALL);
    check("lit_stall_status", obs_status, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end
endmodule
